instr_trace_adapter: RTL and testbench

INSTR_TRACE_ADAPTER -- requirements
Module: instr_trace_adapter

---
 rtl/instr_trace_adapter.sv | 130 +++++++++++++
 tb/tb_instr_trace_adapter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_trace_adapter.sv
// Instruction trace adapter: captures retired {PC, instr} pairs into a stop-on-full FIFO behind an Avalon-MM slave.
// Optional 32-bit retired-instruction counter is built only when INSTR_TRACE_COUNTER_EN is defined.
module instr_trace_adapter #(
  parameter int INSTR_WIDTH = 16,
  parameter int PC_WIDTH    = 10,
  parameter int DEPTH       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             avl_address,
  input  logic                   avl_read,
  input  logic                   avl_write,
  input  logic [15:0]            avl_writedata,
  output logic [15:0]            avl_readdata,
  input  logic [INSTR_WIDTH-1:0] current_instr,
  input  logic [PC_WIDTH-1:0]    current_pc,
  input  logic                   instr_valid
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [CNT_W-1:0]       count;
  logic                   overflow;
  logic                   armed;

  logic        full;
  logic        empty;
  logic        ctrl_wr;
  logic        clear;
  logic        pop;
  logic        capture;
  logic        push;
  logic        ovf_set;
  logic [15:0] rd_data;
  logic        unused_wdata;

  function automatic logic [15:0] zext_instr(input logic [INSTR_WIDTH-1:0] v);
    return 16'(v);
  endfunction

  function automatic logic [15:0] zext_pc(input logic [PC_WIDTH-1:0] v);
    return 16'(v);
  endfunction

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign ctrl_wr = avl_write && (avl_address == 3'd3);
  assign clear   = ctrl_wr && avl_writedata[1];
  assign pop     = avl_read && (avl_address == 3'd5) && !empty;
  assign capture = armed && instr_valid;
  // A pop in the same cycle frees the slot, so a capture on a full buffer still lands.
  assign push    = capture && (!full || pop) && !clear;
  assign ovf_set = capture && full && !pop;

  assign unused_wdata = ^avl_writedata[15:2];

`ifdef INSTR_TRACE_COUNTER_EN
  logic [31:0] retired_cnt;
  logic [31:0] cnt_snap;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
      cnt_snap    <= '0;
    end else begin
      if (instr_valid) retired_cnt <= retired_cnt + 32'd1;
      if (avl_read && (avl_address == 3'd6)) cnt_snap <= {16'd0, retired_cnt[31:16]};
    end
  end
`endif

  always_comb begin
    rd_data = 16'd0;
    case (avl_address)
      3'd0: rd_data = zext_instr(current_instr);
      3'd1: rd_data = zext_pc(current_pc);
      3'd2: rd_data = {overflow, full, empty, armed, 4'b0000, 8'(count)};
      3'd3: rd_data = {15'd0, armed};
      3'd4: rd_data = empty ? 16'd0 : zext_instr(instr_mem[head]);
      3'd5: rd_data = empty ? 16'd0 : zext_pc(pc_mem[head]);
`ifdef INSTR_TRACE_COUNTER_EN
      3'd6: rd_data = retired_cnt[15:0];
      3'd7: rd_data = cnt_snap[15:0];
`endif
      default: rd_data = 16'd0;
    endcase
  end

  // Storage is never reset; entries are invisible while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= current_instr;
      pc_mem[tail]    <= current_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      armed        <= 1'b0;
      avl_readdata <= 16'd0;
    end else begin
      if (avl_read) avl_readdata <= rd_data;
      if (ctrl_wr) armed <= avl_writedata[0];
      if (clear) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
        if (ovf_set) overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_trace_adapter.sv
// Bench for instr_trace_adapter: read-mux vector table plus FIFO, overflow, clear, reset and counter sequences.
module tb_instr_trace_adapter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  avl_address = 3'd0;
  logic        avl_read = 1'b0;
  logic        avl_write = 1'b0;
  logic [15:0] avl_writedata = 16'd0;
  logic [15:0] avl_readdata;
  logic [15:0] current_instr = 16'd0;
  logic [9:0]  current_pc = 10'd0;
  logic        instr_valid = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  string       name_q[$];
  logic        rd_d = 1'b0;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] instr;
    logic [9:0]  pc;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[10];

  logic [15:0] exp6, exp7, exp6b;

  instr_trace_adapter dut (
    .clk           (clk),
    .reset         (reset),
    .avl_address   (avl_address),
    .avl_read      (avl_read),
    .avl_write     (avl_write),
    .avl_writedata (avl_writedata),
    .avl_readdata  (avl_readdata),
    .current_instr (current_instr),
    .current_pc    (current_pc),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    end
  endtask

  // Scoreboard: a read sampled at posedge is compared at the following negedge.
  always @(posedge clk) rd_d <= avl_read && !reset;

  always @(negedge clk) begin
    if (rd_d) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got 0x%04h expected no read", avl_readdata);
      end else begin
        check(name_q.pop_front(), avl_readdata, exp_q.pop_front());
      end
    end
  end

  task automatic rd(input logic [2:0] addr, input logic [15:0] exp, input string nm);
    avl_address = addr;
    avl_read = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    avl_read = 1'b0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [15:0] data);
    avl_address = addr;
    avl_writedata = data;
    avl_write = 1'b1;
    @(negedge clk);
    avl_write = 1'b0;
  endtask

  task automatic cap(input logic [9:0] pc, input logic [15:0] instr);
    current_pc = pc;
    current_instr = instr;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    finish_run();
  end

  initial begin
    vecs[0] = '{3'd0, 16'hABCD, 10'h000, 16'hABCD};
    vecs[1] = '{3'd1, 16'h0000, 10'h3FF, 16'h03FF};
    vecs[2] = '{3'd0, 16'h0000, 10'h155, 16'h0000};
    vecs[3] = '{3'd1, 16'hFFFF, 10'h2AA, 16'h02AA};
    vecs[4] = '{3'd2, 16'h1234, 10'h001, 16'h2000};
    vecs[5] = '{3'd3, 16'h1234, 10'h001, 16'h0000};
    vecs[6] = '{3'd4, 16'h1234, 10'h001, 16'h0000};
    vecs[7] = '{3'd5, 16'h1234, 10'h001, 16'h0000};
    vecs[8] = '{3'd6, 16'h5A5A, 10'h0F0, 16'h0000};
    vecs[9] = '{3'd7, 16'hA5A5, 10'h00F, 16'h0000};
`ifdef INSTR_TRACE_COUNTER_EN
    exp6 = 16'h0005; exp7 = 16'h0001; exp6b = 16'h0006;
`else
    exp6 = 16'h0000; exp7 = 16'h0000; exp6b = 16'h0000;
`endif

    repeat (3) @(negedge clk);
    check("reset_readdata", avl_readdata, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      current_instr = vecs[i].instr;
      current_pc = vecs[i].pc;
      rd(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_addr%0d", i, vecs[i].addr));
    end

    current_instr = 16'hABCD;
    rd(3'd0, 16'hABCD, "live_instr");
    current_instr = 16'h1234;
    repeat (2) @(negedge clk);
    check("readdata_hold", avl_readdata, 16'hABCD);

    wr(3'd3, 16'h0001);
    rd(3'd3, 16'h0001, "ctrl_armed");
    cap(10'h010, 16'h1110);
    cap(10'h011, 16'h2221);
    cap(10'h012, 16'h3332);
    wr(3'd0, 16'h0002);
    wr(3'd7, 16'h0000);
    rd(3'd2, 16'h1003, "status_cnt3");
    rd(3'd4, 16'h1110, "peek0");
    rd(3'd5, 16'h0010, "pop0");
    rd(3'd4, 16'h2221, "peek1");
    rd(3'd5, 16'h0011, "pop1");
    rd(3'd5, 16'h0012, "pop2");
    rd(3'd2, 16'h3000, "status_drained");
    rd(3'd5, 16'h0000, "pop_empty");
    rd(3'd4, 16'h0000, "peek_empty");
    rd(3'd2, 16'h3000, "status_after_empty_pop");

    for (int i = 0; i < 17; i++) cap(10'h100 + 10'(i), 16'h4000 + 16'(i));
    rd(3'd2, 16'hD010, "status_overflow");
    rd(3'd4, 16'h4000, "peek_first_kept");
    rd(3'd5, 16'h0100, "pop_first_kept");
    rd(3'd2, 16'h900F, "status_sticky_ovf");
    wr(3'd3, 16'h0003);
    rd(3'd2, 16'h3000, "status_cleared");
    rd(3'd3, 16'h0001, "ctrl_bit1_selfclear");

    for (int i = 0; i < 16; i++) cap(10'h200 + 10'(i), 16'h6000 + 16'(i));
    rd(3'd2, 16'h5010, "status_full");
    avl_address = 3'd5;
    avl_read = 1'b1;
    current_pc = 10'h2AA;
    current_instr = 16'h7AAA;
    instr_valid = 1'b1;
    exp_q.push_back(16'h0200);
    name_q.push_back("pop_with_capture");
    @(negedge clk);
    avl_read = 1'b0;
    instr_valid = 1'b0;
    rd(3'd2, 16'h5010, "status_full_no_ovf");
    for (int i = 1; i < 16; i++) rd(3'd5, 16'h0200 + 16'(i), $sformatf("drain%0d", i));
    rd(3'd4, 16'h7AAA, "peek_wrapped");
    rd(3'd5, 16'h02AA, "pop_wrapped");
    rd(3'd2, 16'h3000, "status_drained2");
    cap(10'h050, 16'h0050);
    cap(10'h051, 16'h0051);
    cap(10'h052, 16'h0052);
    rd(3'd2, 16'h1003, "status_before_clear");
    wr(3'd3, 16'h0003);
    rd(3'd2, 16'h3000, "status_after_clear");

    avl_address = 3'd3;
    avl_writedata = 16'h0003;
    avl_write = 1'b1;
    current_pc = 10'h077;
    instr_valid = 1'b1;
    @(negedge clk);
    avl_write = 1'b0;
    instr_valid = 1'b0;
    rd(3'd2, 16'h3000, "clear_beats_capture");

    cap(10'h301, 16'h0301);
    cap(10'h302, 16'h0302);
    wr(3'd3, 16'h0000);
    cap(10'h303, 16'h0303);
    rd(3'd2, 16'h0002, "status_disarmed");
    rd(3'd3, 16'h0000, "ctrl_disarmed");
    rd(3'd5, 16'h0301, "pop_disarmed0");
    rd(3'd5, 16'h0302, "pop_disarmed1");
    rd(3'd2, 16'h2000, "status_disarmed_empty");

    wr(3'd3, 16'h0001);
    for (int i = 0; i < 5; i++) cap(10'h0A0 + 10'(i), 16'h00A0);
    rd(3'd2, 16'h1005, "status_cnt5");
    reset = 1'b1;
    instr_valid = 1'b1;
    current_pc = 10'h0AF;
    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b0;
    check("reset_mid_readdata", avl_readdata, 16'h0000);
    rd(3'd2, 16'h2000, "status_after_reset");
    rd(3'd3, 16'h0000, "ctrl_after_reset");

    instr_valid = 1'b1;
    repeat (32'h10005) @(negedge clk);
    instr_valid = 1'b0;
    rd(3'd6, exp6, "counter_low");
    rd(3'd7, exp7, "counter_snap");
    cap(10'h000, 16'h0000);
    rd(3'd7, exp7, "counter_snap_held");
    rd(3'd6, exp6b, "counter_low_next");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    finish_run();
  end
endmodule
